// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory initiator: FSM state encoding,
// default geometry, and the address-XOR-seed test pattern.
package mem_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    FIN    = 3'd5
  } state_t;

  // Test pattern: address XOR seed, computed at 32 bits; callers truncate.
  function automatic logic [31:0] pattern_fn(input logic [31:0] addr,
                                             input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Expected-data generator. One combinational instance feeds both the write
// data path and the read-compare path so they can never disagree.
module mem_pattern_gen
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEF_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      seed,
  output logic [WIDTH-1:0]      data
);

  assign data = WIDTH'(pattern_fn(32'(addr), 32'(seed)));

endmodule

// File: rtl/mem_initiator.sv
// Memory self-test initiator: on start, writes addr^seed to every word, then
// reads each word back and counts mismatches. Every request is followed by
// one idle cycle so a stale ready is never consumed.
// Optional build macro MEM_INITIATOR_TIMEOUT_EN adds a ready-wait watchdog
// that aborts the run to FIN after TIMEOUT cycles without mem_ready.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  localparam int ERR_W = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
  logic                  pass_q, pass_d;
  logic                  to_q, to_d;
  logic [WIDTH-1:0]      exp_data;
  logic                  last_addr;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_expired;
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));
`endif

  mem_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pattern (
    .addr (addr_q),
    .seed (seed_q),
    .data (exp_data)
  );

  assign last_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1));

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    pass_d    = pass_q;
    to_d      = to_q;
    mem_valid = 1'b0;
    mem_wr_rd = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;
    done      = 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
    wait_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        mem_addr = '0;
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          addr_d  = '0;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        mem_valid = 1'b1;
        mem_wr_rd = 1'b1;
        mem_wdata = exp_data;
        if (mem_ready) begin
          state_d = WR_GAP;
        end
`ifdef MEM_INITIATOR_TIMEOUT_EN
        else if (wait_expired) begin
          to_d    = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      WR_GAP: begin
        mem_wr_rd = 1'b1;
        mem_wdata = exp_data;
        if (last_addr) begin
          addr_d  = '0;
          state_d = RD_REQ;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          if (mem_rdata != exp_data) begin
            if (err_q == '0) ferr_d = addr_q;
            if (err_q != ERR_W'(DEPTH)) err_d = err_q + ERR_W'(1);
          end
          state_d = RD_GAP;
        end
`ifdef MEM_INITIATOR_TIMEOUT_EN
        else if (wait_expired) begin
          to_d    = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      RD_GAP: begin
        if (last_addr) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RD_REQ;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Resolve the verdict on the edge entering FIN so pass is valid with done.
    if (state_d == FIN && state_q != FIN) begin
      pass_d = (err_d == '0) && !to_d;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

`ifdef MEM_INITIATOR_TIMEOUT_EN
  // Ready-wait counter, restarted on every entry into a request state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) wait_q <= '0;
    else      wait_q <= wait_d;
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy           = (state_q != IDLE);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;

endmodule
